// File: rtl/mc_ctrl.sv
// Multi-cycle main controller for the MIPS-lite core: sequences fetch/decode/
// execute/memory/write-back, decodes datapath selects and gates write enables by state.
module mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       ir_we,
    output logic       pc_we,
    output logic       reg_we,
    output logic       mem_we,
    output logic [2:0] npc_sel,
    output logic [2:0] alu_op,
    output logic       alu_src,
    output logic       ext_op,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWR  = 4'd4,
        S_WBMEM  = 4'd5,
        S_WBALU  = 4'd6,
        S_BRANCH = 4'd7,
        S_JUMP   = 4'd8,
        S_SKIP   = 4'd9
    } state_t;

    state_t state_q, state_d;

    logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw;
    logic is_beq, is_bne, is_j, is_jal;
    logic is_alu_class, is_branch, is_jump;

    assign is_r    = (opcode == 6'b000000);
    assign is_addu = is_r && (funct == 6'b100001);
    assign is_subu = is_r && (funct == 6'b100011);
    assign is_jr   = is_r && (funct == 6'b001000);
    assign is_ori  = (opcode == 6'b001101);
    assign is_lui  = (opcode == 6'b001111);
    assign is_lw   = (opcode == 6'b100011);
    assign is_sw   = (opcode == 6'b101011);
    assign is_beq  = (opcode == 6'b000100);
    assign is_bne  = (opcode == 6'b000101);
    assign is_j    = (opcode == 6'b000010);
    assign is_jal  = (opcode == 6'b000011);

    assign is_alu_class = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw;
    assign is_branch    = is_beq | is_bne;
    assign is_jump      = is_j | is_jal | is_jr;

    // Branch resolution lives in the next-PC unit; zero is deliberately ignored here.
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (is_alu_class)   state_d = S_EXEC;
                else if (is_branch) state_d = S_BRANCH;
                else if (is_jump)   state_d = S_JUMP;
                else                state_d = S_SKIP;
            end
            S_EXEC: begin
                if (is_lw)      state_d = S_MEMRD;
                else if (is_sw) state_d = S_MEMWR;
                else            state_d = S_WBALU;
            end
            S_MEMRD: state_d = S_WBMEM;
            default: state_d = S_FETCH;
        endcase
    end

    // Enables are Moore decodes of state; reset overrides them immediately.
    always_comb begin
        ir_we  = 1'b0;
        pc_we  = 1'b0;
        reg_we = 1'b0;
        mem_we = 1'b0;
        case (state_q)
            S_FETCH:  ir_we = 1'b1;
            S_MEMWR:  begin mem_we = 1'b1; pc_we = 1'b1; end
            S_WBMEM:  begin reg_we = 1'b1; pc_we = 1'b1; end
            S_WBALU:  begin reg_we = 1'b1; pc_we = 1'b1; end
            S_BRANCH: pc_we = 1'b1;
            S_JUMP:   begin pc_we = 1'b1; reg_we = is_jal; end
            S_SKIP:   pc_we = 1'b1;
            default:  ;
        endcase
        if (!reset) begin
            ir_we  = 1'b0;
            pc_we  = 1'b0;
            reg_we = 1'b0;
            mem_we = 1'b0;
        end
    end

    always_comb begin
        npc_sel = 3'b000;
        alu_op  = 3'b000;
        alu_src = 1'b0;
        ext_op  = 1'b0;
        reg_dst = 2'b00;
        wd_sel  = 2'b00;
        if (is_addu) begin
            reg_dst = 2'b01;
        end else if (is_subu) begin
            alu_op = 3'b001; reg_dst = 2'b01;
        end else if (is_ori) begin
            alu_op = 3'b010; alu_src = 1'b1;
        end else if (is_lui) begin
            alu_op = 3'b011; alu_src = 1'b1;
        end else if (is_lw) begin
            alu_src = 1'b1; ext_op = 1'b1; wd_sel = 2'b01;
        end else if (is_sw) begin
            alu_src = 1'b1; ext_op = 1'b1;
        end else if (is_beq) begin
            alu_op = 3'b001; npc_sel = 3'b001;
        end else if (is_bne) begin
            alu_op = 3'b001; npc_sel = 3'b100;
        end else if (is_j) begin
            npc_sel = 3'b010;
        end else if (is_jal) begin
            npc_sel = 3'b010; reg_dst = 2'b10; wd_sel = 2'b10;
        end else if (is_jr) begin
            npc_sel = 3'b011;
        end
        if (state_q == S_SKIP) npc_sel = 3'b000;
    end

    assign state = state_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-scenario tasks with hand-computed state sequences and outputs.
module tb_mc_ctrl;
    logic       clk, reset, zero;
    logic [5:0] opcode, funct;
    logic       ir_we, pc_we, reg_we, mem_we, alu_src, ext_op;
    logic [2:0] npc_sel, alu_op;
    logic [1:0] reg_dst, wd_sel;
    logic [3:0] state;

    int vecs = 0;
    int miscompares = 0;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .mem_we(mem_we),
        .npc_sel(npc_sel), .alu_op(alu_op), .alu_src(alu_src), .ext_op(ext_op),
        .reg_dst(reg_dst), .wd_sel(wd_sel), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; opcode = 6'b100011; funct = 6'b0; zero = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if (state !== 4'd0 || {ir_we, pc_we, reg_we, mem_we} !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: state=%0d en=%b, expected state=0 en=0000",
                         i, state, {ir_we, pc_we, reg_we, mem_we});
            end
            tick();
        end
        reset = 1'b1;
        #1;
        vecs++;
        if (ir_we !== 1'b1 || state !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_release: ir_we=%b state=%0d, expected ir_we=1 state=0", ir_we, state);
        end
        tick();
        vecs++;
        if (state !== 4'd1) begin
            miscompares++;
            $display("FAIL reset_first_decode: state=%0d, expected 1", state);
        end
        repeat (4) tick();
    endtask

    task automatic test_lw;
        logic [3:0] exp_st[5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5};
        int pcs = 0;
        opcode = 6'b100011; funct = 6'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            vecs++;
            if (state !== exp_st[i] || reg_we !== (i == 4) || pc_we !== (i == 4) || mem_we !== 1'b0) begin
                miscompares++;
                $display("FAIL lw_cycle[%0d]: state=%0d reg_we=%b pc_we=%b mem_we=%b, expected state=%0d reg_we=%b pc_we=%b mem_we=0",
                         i, state, reg_we, pc_we, mem_we, exp_st[i], (i == 4), (i == 4));
            end
            if (pc_we === 1'b1) pcs++;
            if (i == 4) begin
                vecs++;
                if (wd_sel !== 2'b01 || ext_op !== 1'b1 || alu_src !== 1'b1) begin
                    miscompares++;
                    $display("FAIL lw_selects: wd_sel=%b ext_op=%b alu_src=%b, expected 01 1 1", wd_sel, ext_op, alu_src);
                end
            end
            tick();
        end
        vecs++;
        if (pcs != 1 || state !== 4'd0) begin
            miscompares++;
            $display("FAIL lw_retire: pc_we count=%0d state=%0d, expected 1 and 0", pcs, state);
        end
    endtask

    task automatic test_sw;
        logic [3:0] exp_st[4] = '{4'd0, 4'd1, 4'd2, 4'd4};
        opcode = 6'b101011;
        #1;
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (state !== exp_st[i] || mem_we !== (i == 3) || pc_we !== (i == 3) || reg_we !== 1'b0) begin
                miscompares++;
                $display("FAIL sw_cycle[%0d]: state=%0d mem_we=%b pc_we=%b reg_we=%b, expected state=%0d mem_we=%b pc_we=%b reg_we=0",
                         i, state, mem_we, pc_we, reg_we, exp_st[i], (i == 3), (i == 3));
            end
            tick();
        end
        vecs++;
        if (state !== 4'd0) begin
            miscompares++;
            $display("FAIL sw_next: state=%0d, expected 0", state);
        end
    endtask

    task automatic test_bne;
        logic [3:0]  exp_st[3] = '{4'd0, 4'd1, 4'd7};
        logic [19:0] snap[3];
        logic [19:0] cur;
        opcode = 6'b000101;
        for (int z = 0; z < 2; z++) begin
            zero = z[0];
            #1;
            for (int i = 0; i < 3; i++) begin
                cur = {ir_we, pc_we, reg_we, mem_we, npc_sel, alu_op, alu_src, ext_op, reg_dst, wd_sel, state};
                vecs++;
                if (state !== exp_st[i] || pc_we !== (i == 2) || npc_sel !== 3'b100 || alu_op !== 3'b001) begin
                    miscompares++;
                    $display("FAIL bne_z%0d_cycle[%0d]: state=%0d pc_we=%b npc_sel=%b alu_op=%b, expected state=%0d pc_we=%b npc_sel=100 alu_op=001",
                             z, i, state, pc_we, npc_sel, alu_op, exp_st[i], (i == 2));
                end
                if (z == 0) snap[i] = cur;
                else begin
                    vecs++;
                    if (cur !== snap[i]) begin
                        miscompares++;
                        $display("FAIL bne_zero_indep[%0d]: outputs=%h, expected %h", i, cur, snap[i]);
                    end
                end
                tick();
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jal;
        opcode = 6'b000011;
        #1;
        tick(); tick();
        vecs++;
        if (state !== 4'd8 || reg_we !== 1'b1 || pc_we !== 1'b1 || reg_dst !== 2'b10 || wd_sel !== 2'b10 || npc_sel !== 3'b010) begin
            miscompares++;
            $display("FAIL jal_jump: state=%0d reg_we=%b pc_we=%b reg_dst=%b wd_sel=%b npc_sel=%b, expected 8 1 1 10 10 010",
                     state, reg_we, pc_we, reg_dst, wd_sel, npc_sel);
        end
        tick();
    endtask

    task automatic test_jr;
        opcode = 6'b000000; funct = 6'b001000;
        #1;
        tick(); tick();
        vecs++;
        if (state !== 4'd8 || npc_sel !== 3'b011 || reg_we !== 1'b0 || pc_we !== 1'b1) begin
            miscompares++;
            $display("FAIL jr_jump: state=%0d npc_sel=%b reg_we=%b pc_we=%b, expected 8 011 0 1",
                     state, npc_sel, reg_we, pc_we);
        end
        tick();
        funct = 6'b0;
    endtask

    task automatic test_unknown;
        logic [3:0] exp_st[3] = '{4'd0, 4'd1, 4'd9};
        opcode = 6'b111111;
        #1;
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if (state !== exp_st[i] || pc_we !== (i == 2) || npc_sel !== 3'b000 || reg_we !== 1'b0 || mem_we !== 1'b0) begin
                miscompares++;
                $display("FAIL unknown_cycle[%0d]: state=%0d pc_we=%b npc_sel=%b reg_we=%b mem_we=%b, expected %0d %b 000 0 0",
                         i, state, pc_we, npc_sel, reg_we, mem_we, exp_st[i], (i == 2));
            end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0] ops[4]  = '{6'b000000, 6'b000000, 6'b001101, 6'b001111};
        logic [5:0] fns[4]  = '{6'b100001, 6'b100011, 6'b000000, 6'b000000};
        logic [2:0] alus[4] = '{3'b000, 3'b001, 3'b010, 3'b011};
        logic       srcs[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [1:0] dsts[4] = '{2'b01, 2'b01, 2'b00, 2'b00};
        logic [3:0] exp_st[4] = '{4'd0, 4'd1, 4'd2, 4'd6};
        for (int k = 0; k < 4; k++) begin
            opcode = ops[k]; funct = fns[k];
            #1;
            vecs++;
            if (alu_op !== alus[k] || alu_src !== srcs[k] || reg_dst !== dsts[k] || wd_sel !== 2'b00 || ext_op !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_selects[%0d]: alu_op=%b alu_src=%b reg_dst=%b wd_sel=%b ext_op=%b, expected %b %b %b 00 0",
                         k, alu_op, alu_src, reg_dst, wd_sel, ext_op, alus[k], srcs[k], dsts[k]);
            end
            for (int i = 0; i < 4; i++) begin
                vecs++;
                if (state !== exp_st[i] || pc_we !== (i == 3) || reg_we !== (i == 3) || mem_we !== 1'b0 || ir_we !== (i == 0)) begin
                    miscompares++;
                    $display("FAIL b2b_cycle[%0d][%0d]: state=%0d pc_we=%b reg_we=%b mem_we=%b ir_we=%b, expected %0d %b %b 0 %b",
                             k, i, state, pc_we, reg_we, mem_we, ir_we, exp_st[i], (i == 3), (i == 3), (i == 0));
                end
                tick();
            end
        end
        funct = 6'b0;
    endtask

    task automatic test_mid_reset;
        opcode = 6'b000000; funct = 6'b100001;
        #1;
        tick(); tick();
        vecs++;
        if (state !== 4'd2) begin
            miscompares++;
            $display("FAIL midrst_exec: state=%0d, expected 2", state);
        end
        #2 reset = 1'b0;
        #1;
        vecs++;
        if (state !== 4'd0 || {ir_we, pc_we, reg_we, mem_we} !== 4'b0000) begin
            miscompares++;
            $display("FAIL midrst_async: state=%0d en=%b, expected 0 0000", state, {ir_we, pc_we, reg_we, mem_we});
        end
        tick();
        vecs++;
        if (state !== 4'd0 || {ir_we, pc_we, reg_we, mem_we} !== 4'b0000) begin
            miscompares++;
            $display("FAIL midrst_hold: state=%0d en=%b, expected 0 0000", state, {ir_we, pc_we, reg_we, mem_we});
        end
        reset = 1'b1;
        #1;
        vecs++;
        if (state !== 4'd0 || {ir_we, pc_we, reg_we, mem_we} !== 4'b1000) begin
            miscompares++;
            $display("FAIL midrst_refetch: state=%0d en=%b, expected 0 1000", state, {ir_we, pc_we, reg_we, mem_we});
        end
        tick(); tick(); tick();
        vecs++;
        if (state !== 4'd6 || pc_we !== 1'b1 || reg_we !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_new_retire: state=%0d pc_we=%b reg_we=%b, expected 6 1 1", state, pc_we, reg_we);
        end
        tick();
        funct = 6'b0;
    endtask

    initial begin
        reset = 1'b0; zero = 1'b0; opcode = 6'b0; funct = 6'b0;
        test_reset();
        test_lw();
        test_sw();
        test_bne();
        test_jal();
        test_jr();
        test_unknown();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
